// File: rtl/uart_tx_core_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding and line/parity constants.
package uart_tx_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register and bit counter; shifts out the frame's data bits LSB first.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CW-1:0]         cnt_q;

    // cnt_q counts shifts modulo DATA_WIDTH, so it is back at zero exactly while
    // the last data bit is on the line; that is the DATA exit condition.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shift_q <= P_DATA;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
            cnt_q   <= (cnt_q == CW'(DATA_WIDTH - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    assign ser_bit  = shift_q[0];
    assign ser_done = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
module uart_tx_core
    import uart_tx_core_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy,
    output tx_state_t             fsm_state
);

    // Handshake: Data_Valid is accepted at a rising edge only in IDLE or in STOP's
    // closing cycle; otherwise it is ignored. Busy=1 means a frame is on the line.

    tx_state_t state_q, state_d;
    logic      load, shift_en;
    logic      tx_d, busy_d;
    logic      ser_bit, ser_done;
    logic      par_en_q, par_typ_q, data_xor_q;

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .shift_en (shift_en),
        .P_DATA   (P_DATA),
        .ser_bit  (ser_bit),
        .ser_done (ser_done)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Data_Valid) begin
                    state_d = ST_START;
                    load    = 1'b1;
                end
            end
            ST_START:  state_d = ST_DATA;
            ST_DATA: begin
                if (ser_done) state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP: begin
                if (Data_Valid) begin
                    state_d = ST_START;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase

        // Outputs are registered from the state being entered, so the line
        // changes on the same edge as the state.
        shift_en = (state_d == ST_DATA);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = ser_bit;
            ST_PARITY: tx_d = data_xor_q ^ (par_typ_q == PAR_ODD);
            default:   tx_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            TX_OUT     <= IDLE_LEVEL;
            Busy       <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            data_xor_q <= 1'b0;
        end else begin
            state_q <= state_d;
            TX_OUT  <= tx_d;
            Busy    <= busy_d;
            if (load) begin
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                data_xor_q <= ^P_DATA;
            end
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: frame-level model, vector table, corner sequences, random traffic.
module tb_uart_tx_core;
    import uart_tx_core_pkg::*;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Data_Valid = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          TX_OUT;
    logic          Busy;
    tx_state_t     fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [0:0] exp_q[$];
    logic       exp_busy = 1'b0;
    logic       obs_tx, obs_busy;

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          pt;
        int            len;
        logic          par;
    } vec_t;
    vec_t vecs[8];

    uart_tx_core #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .fsm_state  (fsm_state)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, parity (ones count xor type), stop 1.
    task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(1'($countones(d) & 1) ^ pt);
        exp_q.push_back(1'b1);
    endtask

    // Advance one clock, then compare the line against the next expected bit.
    task automatic step();
        logic e;
        @(posedge CLK);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_busy = 1'b1;
        end else begin
            e = 1'b1;
            exp_busy = 1'b0;
        end
        obs_tx   = TX_OUT;
        obs_busy = Busy;
        chk("tx_out", 32'(TX_OUT), 32'(e));
        chk("busy", 32'(Busy), 32'(exp_busy));
    endtask

    task automatic run_vec(input logic [DW-1:0] d, input logic pe, input logic pt,
                           output int busy_n, output logic par_seen);
        P_DATA = d;
        PAR_EN = pe;
        PAR_TYP = pt;
        Data_Valid = 1'b1;
        push_frame(d, pe, pt);
        busy_n = 0;
        par_seen = 1'b0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (c == 0) begin
                Data_Valid = 1'b0;
                P_DATA = DW'($urandom);
                PAR_EN = 1'($urandom_range(0, 1));
                PAR_TYP = 1'($urandom_range(0, 1));
            end
            if (obs_busy) busy_n++;
            if (c == DW + 1) par_seen = obs_tx;
            if (!obs_busy) break;
        end
    endtask

    initial begin
        int            busy_n, guard, g;
        logic          par_seen, pe, pt, dropped;
        logic [DW-1:0] d;
        logic [19:0]   col;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 11, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 11, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 11, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 11, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 11, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0, 10, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 11, 1'b0};
        vecs[7] = '{8'h7F, 1'b1, 1'b0, 11, 1'b1};

        // Reset, then a long quiet stretch with no requests.
        RST = 1'b0;
        repeat (3) step();
        chk("reset_state", 32'(fsm_state), 32'(ST_IDLE));
        RST = 1'b1;
        repeat (50) step();

        foreach (vecs[i]) begin
            run_vec(vecs[i].data, vecs[i].pe, vecs[i].pt, busy_n, par_seen);
            chk("frame_len", 32'(busy_n), 32'(vecs[i].len));
            if (vecs[i].pe) chk("parity_bit", 32'(par_seen), 32'(vecs[i].par));
        end

        // Back-to-back: 0x55 then 0xFF with the second request in the stop cycle.
        col = '0;
        dropped = 1'b0;
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        push_frame(8'h55, 1'b0, 1'b0);
        step();
        col = {col[18:0], obs_tx};
        Data_Valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            step();
            col = {col[18:0], obs_tx};
            dropped |= !obs_busy;
        end
        P_DATA = 8'hFF; Data_Valid = 1'b1;
        push_frame(8'hFF, 1'b0, 1'b0);
        step();
        col = {col[18:0], obs_tx};
        dropped |= !obs_busy;
        Data_Valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            step();
            col = {col[18:0], obs_tx};
            dropped |= !obs_busy;
        end
        chk("b2b_bits", 32'(col), 32'(20'b01010101010111111111));
        chk("b2b_busy_drop", 32'(dropped), 32'(1'b0));
        repeat (2) step();

        // A request during DATA bit 3 is ignored entirely.
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        push_frame(8'h3C, 1'b0, 1'b0);
        step();
        Data_Valid = 1'b0;
        repeat (4) step();
        P_DATA = 8'h00; PAR_EN = 1'b1; Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        guard = 0;
        while (exp_busy && guard < 20) begin
            step();
            guard++;
        end
        repeat (3) step();
        chk("ignored_req_idle", 32'(fsm_state), 32'(ST_IDLE));

        // Reset during DATA bit 4, then a clean frame.
        P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        push_frame(8'hC3, 1'b1, 1'b1);
        step();
        Data_Valid = 1'b0;
        repeat (5) step();
        RST = 1'b0;
        exp_q.delete();
        step();
        chk("midframe_reset_state", 32'(fsm_state), 32'(ST_IDLE));
        RST = 1'b1;
        repeat (2) step();
        run_vec(8'h96, 1'b1, 1'b0, busy_n, par_seen);
        chk("post_reset_len", 32'(busy_n), 32'd11);
        chk("post_reset_parity", 32'(par_seen), 32'(1'b0));

        // Random traffic: random gaps (0 = back-to-back) and ignored requests mid-frame.
        for (int n = 0; n < 30; n++) begin
            g = $urandom_range(0, 3);
            d = DW'($urandom);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            guard = 0;
            if (g == 0) begin
                while (exp_q.size() > 0 && guard < 30) begin
                    step();
                    guard++;
                    Data_Valid = (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    P_DATA = DW'($urandom);
                end
            end else begin
                while (exp_busy && guard < 30) begin
                    step();
                    guard++;
                    Data_Valid = (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    P_DATA = DW'($urandom);
                end
                repeat (g - 1) step();
            end
            chk("wait_bound", 32'(guard < 30), 32'd1);
            P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
            push_frame(d, pe, pt);
            step();
            Data_Valid = 1'b0;
        end
        guard = 0;
        while ((exp_busy || exp_q.size() > 0) && guard < 20) begin
            step();
            guard++;
        end
        chk("drain_bound", 32'(guard < 20), 32'd1);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
